// File: rtl/regfile_bank_loader_pkg.sv
// Shared register-file package: default port/address widths and the
// loader FSM state encoding.
package regfile_bank_loader_pkg;

    localparam int DEFAULT_PORT_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_EVEN = 2'b00,
        ST_ODD  = 2'b01,
        ST_WAIT = 2'b10
    } loader_state_t;

endpackage

// File: rtl/regfile_bank_loader_if.sv
// Upstream word stream into the bank loader (valid/ready with tile-end marker).
interface regfile_bank_loader_if
    import regfile_bank_loader_pkg::*;
#(
    parameter int PORT_WIDTH = DEFAULT_PORT_WIDTH
) ();

    logic [PORT_WIDTH-1:0] inData;
    logic                  inValid;
    logic                  inLast;
    logic                  inReady;

    modport master (output inData, output inValid, output inLast, input inReady);
    modport slave  (input inData, input inValid, input inLast, output inReady);

endinterface

// File: rtl/regfile_bank_loader.sv
// Packs an upstream word stream into 2-word register-file writes, filling two
// banks alternately and handing each closed tile to the consumer.
module regfile_bank_loader
    import regfile_bank_loader_pkg::*;
#(
    parameter int PORT_WIDTH = DEFAULT_PORT_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    regfile_bank_loader_if.slave  up,
    output logic                  writeBank,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-2:0] writeAddrTransferBlock,
    output logic [PORT_WIDTH-1:0] writeData0,
    output logic [PORT_WIDTH-1:0] writeData1,
    output logic [1:0]            bankValid,
    output logic [ADDR_WIDTH:0]   bankWords0,
    output logic [ADDR_WIDTH:0]   bankWords1,
    input  logic                  releaseValid,
    input  logic                  releaseBank
);

    localparam int BW = ADDR_WIDTH - 1;
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [BW-1:0] LAST_BLOCK = {BW{1'b1}};

    loader_state_t         r_state;
    loader_state_t         w_state_next;
    logic                  r_fill_bank;
    logic [BW-1:0]         r_block;
    logic [CW-1:0]         r_count;
    logic [PORT_WIDTH-1:0] r_held;
    logic                  r_close_pend;
    logic [CW-1:0]         r_close_words;
    logic [1:0]            r_bank_valid;
    logic [CW-1:0]         r_bank_words0;
    logic [CW-1:0]         r_bank_words1;
    logic                  r_we;
    logic                  r_wbank;
    logic [BW-1:0]         r_wblock;
    logic [PORT_WIDTH-1:0] r_wd0;
    logic [PORT_WIDTH-1:0] r_wd1;

    logic                  w_fill_busy;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_in_odd;
    logic                  w_write;
    logic                  w_close;
    logic [PORT_WIDTH-1:0] w_wd0;
    logic [PORT_WIDTH-1:0] w_wd1;
    logic [CW-1:0]         w_count_next;
    logic [1:0]            w_rel_mask;
    logic [1:0]            w_set_mask;
    logic [1:0]            w_bank_valid_next;

    // The fill bank is blocked while its tile is still owned by the consumer
    // and for the one bubble cycle in which a closing write is in flight.
    assign w_fill_busy  = r_bank_valid[r_fill_bank];
    assign w_ready      = !reset && (r_state != ST_WAIT) && !w_fill_busy && !r_close_pend;
    assign w_accept     = up.inValid && w_ready;
    assign w_in_odd     = (r_state == ST_ODD);
    assign w_wd0        = w_in_odd ? r_held : up.inData;
    assign w_wd1        = w_in_odd ? up.inData : {PORT_WIDTH{1'b0}};
    assign w_count_next = r_count + (w_in_odd ? CW'(2) : CW'(1));

    assign w_rel_mask        = releaseValid ? (2'b01 << releaseBank) : 2'b00;
    assign w_set_mask        = r_close_pend ? (2'b01 << r_fill_bank) : 2'b00;
    assign w_bank_valid_next = (r_bank_valid & ~w_rel_mask) | w_set_mask;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_EVEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_write      = 1'b0;
        w_close      = 1'b0;
        case (r_state)
            ST_EVEN: begin
                if (w_accept) begin
                    if (up.inLast) begin
                        w_write = 1'b1;
                        w_close = 1'b1;
                    end else begin
                        w_state_next = ST_ODD;
                    end
                end else if (w_fill_busy && !r_close_pend) begin
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_EVEN;
                end
            end
            ST_ODD: begin
                if (w_accept) begin
                    w_write      = 1'b1;
                    w_close      = up.inLast || (r_block == LAST_BLOCK);
                    w_state_next = ST_EVEN;
                end else begin
                    w_state_next = ST_ODD;
                end
            end
            ST_WAIT: begin
                if (!w_fill_busy) begin
                    w_state_next = ST_EVEN;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            default: begin
                w_state_next = ST_EVEN;
            end
        endcase
    end

    // Fill-side bookkeeping; a close retires the tile on the edge that ends the strobe.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fill_bank   <= 1'b0;
            r_block       <= {BW{1'b0}};
            r_count       <= {CW{1'b0}};
            r_held        <= {PORT_WIDTH{1'b0}};
            r_close_pend  <= 1'b0;
            r_close_words <= {CW{1'b0}};
            r_bank_valid  <= 2'b00;
            r_bank_words0 <= {CW{1'b0}};
            r_bank_words1 <= {CW{1'b0}};
        end else begin
            r_close_pend <= w_close;
            r_bank_valid <= w_bank_valid_next;
            if (w_accept && !w_in_odd && !up.inLast) begin
                r_held <= up.inData;
            end
            if (w_write) begin
                r_block       <= r_block + 1'b1;
                r_count       <= w_count_next;
                r_close_words <= w_count_next;
            end
            if (r_close_pend) begin
                r_fill_bank <= ~r_fill_bank;
                r_block     <= {BW{1'b0}};
                r_count     <= {CW{1'b0}};
                if (r_fill_bank) begin
                    r_bank_words1 <= r_close_words;
                end else begin
                    r_bank_words0 <= r_close_words;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_we     <= 1'b0;
            r_wbank  <= 1'b0;
            r_wblock <= {BW{1'b0}};
            r_wd0    <= {PORT_WIDTH{1'b0}};
            r_wd1    <= {PORT_WIDTH{1'b0}};
        end else begin
            r_we <= w_write;
            if (w_write) begin
                r_wbank  <= r_fill_bank;
                r_wblock <= r_block;
                r_wd0    <= w_wd0;
                r_wd1    <= w_wd1;
            end
        end
    end

    assign up.inReady             = w_ready;
    assign writeEnable            = r_we;
    assign writeBank              = r_wbank;
    assign writeAddrTransferBlock = r_wblock;
    assign writeData0             = r_wd0;
    assign writeData1             = r_wd1;
    assign bankValid              = r_bank_valid;
    assign bankWords0             = r_bank_words0;
    assign bankWords1             = r_bank_words1;

endmodule

// File: tb/tb_regfile_bank_loader.sv
// Bench for regfile_bank_loader: directed scenarios plus a randomized stream,
// all checked against a tile-level reference model.
module tb_regfile_bank_loader;
    import regfile_bank_loader_pkg::*;

    localparam int PW = 16;
    localparam int AW = 3;
    localparam int BW = AW - 1;
    localparam int CW = AW + 1;
    localparam int TILE_MAX = 1 << AW;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    regfile_bank_loader_if #(.PORT_WIDTH(PW)) up_if ();

    logic          writeBank;
    logic          writeEnable;
    logic [BW-1:0] writeAddrTransferBlock;
    logic [PW-1:0] writeData0;
    logic [PW-1:0] writeData1;
    logic [1:0]    bankValid;
    logic [CW-1:0] bankWords0;
    logic [CW-1:0] bankWords1;
    logic          releaseValid;
    logic          releaseBank;

    regfile_bank_loader #(.PORT_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clock                  (clock),
        .reset                  (reset),
        .up                     (up_if),
        .writeBank              (writeBank),
        .writeEnable            (writeEnable),
        .writeAddrTransferBlock (writeAddrTransferBlock),
        .writeData0             (writeData0),
        .writeData1             (writeData1),
        .bankValid              (bankValid),
        .bankWords0             (bankWords0),
        .bankWords1             (bankWords1),
        .releaseValid           (releaseValid),
        .releaseBank            (releaseBank)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: words of the open tile, bank ownership, one pending write.
    logic [PW-1:0] tile[$];
    int            m_fill;
    logic [1:0]    m_valid;
    int            m_words[2];
    logic          m_exp_we;
    int            m_exp_bank, m_exp_block, m_exp_words;
    logic [PW-1:0] m_exp_d0, m_exp_d1;
    logic          m_exp_close;
    logic          pend_rst, pend_close, pend_rel;
    int            pend_close_bank, pend_close_words, pend_rel_bank;
    logic          prev_wait;

    logic          last_wbank;
    int            last_wblock;
    logic [PW-1:0] last_wd0, last_wd1;
    int            we_count;

    task automatic model_accept(input logic [PW-1:0] d, input logic l);
        int n;
        int base;
        tile.push_back(d);
        n = tile.size();
        if ((n % 2 == 0) || l) begin
            base        = ((n - 1) / 2) * 2;
            m_exp_we    = 1'b1;
            m_exp_bank  = m_fill;
            m_exp_block = (n - 1) / 2;
            m_exp_d0    = tile[base];
            m_exp_d1    = (n % 2 == 0) ? tile[base+1] : '0;
            m_exp_close = l || (n == TILE_MAX);
            m_exp_words = n;
            if (m_exp_close) tile.delete();
        end
    endtask

    task automatic tick(input logic v, input logic [PW-1:0] d, input logic l,
                        input logic rv, input logic rb, input logic rs, output logic acc);
        logic closing;
        logic exp_ready;
        @(negedge clock);
        if (pend_rst) begin
            tile.delete();
            m_fill     = 0;
            m_valid    = 2'b00;
            m_words[0] = 0;
            m_words[1] = 0;
            m_exp_we   = 1'b0;
        end else begin
            if (pend_close) begin
                m_valid[pend_close_bank] = 1'b1;
                m_words[pend_close_bank] = pend_close_words;
                m_fill                   = 1 - m_fill;
            end
            if (pend_rel) m_valid[pend_rel_bank] = 1'b0;
        end
        pend_rst   = 1'b0;
        pend_close = 1'b0;
        pend_rel   = 1'b0;

        check_eq("writeEnable", 32'(writeEnable), 32'(m_exp_we));
        if (writeEnable) begin
            we_count++;
            last_wbank  = writeBank;
            last_wblock = int'(writeAddrTransferBlock);
            last_wd0    = writeData0;
            last_wd1    = writeData1;
            check_eq("write_to_valid_bank", 32'(bankValid[writeBank]), 32'd0);
            if (m_exp_we) begin
                check_eq("writeBank", 32'(writeBank), 32'(m_exp_bank));
                check_eq("writeBlock", 32'(writeAddrTransferBlock), 32'(m_exp_block));
                check_eq("writeData0", 32'(writeData0), 32'(m_exp_d0));
                check_eq("writeData1", 32'(writeData1), 32'(m_exp_d1));
            end
        end
        check_eq("bankValid", 32'(bankValid), 32'(m_valid));
        check_eq("bankWords0", 32'(bankWords0), 32'(m_words[0]));
        check_eq("bankWords1", 32'(bankWords1), 32'(m_words[1]));

        closing = m_exp_we && m_exp_close;
        if (closing) begin
            pend_close       = 1'b1;
            pend_close_bank  = m_exp_bank;
            pend_close_words = m_exp_words;
        end
        m_exp_we = 1'b0;

        reset         = rs;
        up_if.inValid = v;
        up_if.inData  = d;
        up_if.inLast  = l;
        releaseValid  = rv;
        releaseBank   = rb;
        #1;
        // Ready needs a free fill bank, no closing write, and no WAIT exit cycle.
        exp_ready = !rs && !m_valid[m_fill] && !closing && !prev_wait;
        check_eq("inReady", 32'(up_if.inReady), 32'(exp_ready));
        prev_wait = !rs && m_valid[m_fill] && !closing;

        acc = v && up_if.inReady;
        if (rs) begin
            pend_rst = 1'b1;
        end else begin
            if (acc) model_accept(d, l);
            if (rv) begin
                pend_rel      = 1'b1;
                pend_rel_bank = rb;
            end
        end
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic do_reset(input int n);
        logic acc;
        for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    endtask

    task automatic send_word(input logic [PW-1:0] d, input logic l);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 100 && !acc; i++) tick(1'b1, d, l, 1'b0, 1'b0, 1'b0, acc);
        check_eq("send_timeout", 32'(acc), 32'd1);
    endtask

    initial begin
        logic acc;
        int   sent;
        int   budget;
        logic rv, rb, v, l;

        reset         = 1'b1;
        up_if.inValid = 1'b0;
        up_if.inData  = '0;
        up_if.inLast  = 1'b0;
        releaseValid  = 1'b0;
        releaseBank   = 1'b0;
        pend_rst      = 1'b1;
        pend_close    = 1'b0;
        pend_rel      = 1'b0;
        prev_wait     = 1'b0;
        m_exp_we      = 1'b0;
        m_fill        = 0;
        m_valid       = 2'b00;
        m_words[0]    = 0;
        m_words[1]    = 0;
        we_count      = 0;

        do_reset(2);
        idle(1);
        check_eq("post_reset_ready", 32'(up_if.inReady), 32'd1);

        // Full 8-word tile into bank 0
        for (int i = 1; i <= 8; i++) send_word(PW'(i), (i == 8));
        idle(3);
        check_eq("full_tile_valid", 32'(bankValid), 32'h1);
        check_eq("full_tile_words0", 32'(bankWords0), 32'd8);
        check_eq("full_tile_last_block", 32'(last_wblock), 32'd3);
        check_eq("full_tile_last_d1", 32'(last_wd1), 32'd8);

        // Odd-length tile: last word pairs with zero
        do_reset(1);
        for (int i = 10; i <= 14; i++) send_word(PW'(i), (i == 14));
        idle(3);
        check_eq("odd_tile_block", 32'(last_wblock), 32'd2);
        check_eq("odd_tile_d0", 32'(last_wd0), 32'd14);
        check_eq("odd_tile_d1", 32'(last_wd1), 32'd0);
        check_eq("odd_tile_words0", 32'(bankWords0), 32'd5);

        // Both banks full, then release bank 0
        for (int i = 20; i <= 27; i++) send_word(PW'(i), 1'b0);
        idle(4);
        check_eq("both_full_valid", 32'(bankValid), 32'h3);
        check_eq("both_full_ready", 32'(up_if.inReady), 32'd0);
        tick(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        check_eq("release_ready_1", 32'(up_if.inReady), 32'd0);
        tick(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        check_eq("release_ready_2", 32'(up_if.inReady), 32'd1);
        send_word(PW'(30), 1'b0);
        send_word(PW'(31), 1'b0);
        idle(1);
        check_eq("after_release_bank", 32'(last_wbank), 32'd0);
        check_eq("after_release_block", 32'(last_wblock), 32'd0);

        // Release bank 1 in the very cycle bank 0 closes
        for (int i = 32; i <= 36; i++) send_word(PW'(i), (i == 36));
        tick(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        idle(2);
        check_eq("coincident_valid", 32'(bankValid), 32'h1);
        check_eq("coincident_words0", 32'(bankWords0), 32'd7);

        // Reset mid-pair discards the held word
        do_reset(1);
        for (int i = 40; i <= 42; i++) send_word(PW'(i), 1'b0);
        we_count = 0;
        do_reset(1);
        idle(1);
        check_eq("reset_no_we", 32'(we_count), 32'd0);
        send_word(PW'(50), 1'b0);
        send_word(PW'(51), 1'b0);
        idle(1);
        check_eq("reset_restart_bank", 32'(last_wbank), 32'd0);
        check_eq("reset_restart_block", 32'(last_wblock), 32'd0);
        check_eq("reset_restart_d0", 32'(last_wd0), 32'd50);

        // Random valid gaps, random tile ends, random releases
        do_reset(1);
        sent   = 0;
        budget = 0;
        while (sent < 64 && budget < 3000) begin
            v  = 1'($urandom_range(0, 1));
            l  = ($urandom_range(0, 5) == 0);
            rv = 1'b0;
            rb = 1'b0;
            if (m_valid != 2'b00 && $urandom_range(0, 2) == 0) begin
                rv = 1'b1;
                if (m_valid == 2'b11) rb = 1'($urandom_range(0, 1));
                else rb = m_valid[1];
            end
            tick(v, PW'($urandom_range(0, 16'hFFFF)), l, rv, rb, 1'b0, acc);
            if (acc) sent++;
            budget++;
        end
        check_eq("random_words_sent", 32'(sent), 32'd64);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
